// File: rtl/mlp_inference_sequencer_if.sv
// Sample-in, weight-memory and result-out signal bundle for the SoH inference sequencer.
// The slave side is the sequencer; the master side is its environment.
interface mlp_inference_sequencer_if #(
    parameter int DATA_W  = 32,
    parameter int IN_SIZE = 4,
    parameter int ADDR_W  = 12
);
    logic                      in_valid;
    logic                      in_ready;
    logic [IN_SIZE*DATA_W-1:0] in_data;
    logic                      wmem_rd;
    logic [ADDR_W-1:0]         wmem_addr;
    logic [DATA_W-1:0]         wmem_rdata;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         soh_out;
    logic                      busy;
    logic [1:0]                layer_idx;

    modport slave (
        input  in_valid, in_data, wmem_rdata, out_ready,
        output in_ready, wmem_rd, wmem_addr, out_valid, soh_out, busy, layer_idx
    );
    modport master (
        output in_valid, in_data, wmem_rdata, out_ready,
        input  in_ready, wmem_rd, wmem_addr, out_valid, soh_out, busy, layer_idx
    );
endinterface

// File: rtl/mlp_inference_sequencer.sv
// Runs the 4-64-32-16-1 SoH network through one shared Q16.16 MAC.
// Weights stream from external memory; activations live in two ping-pong buffers.
module mlp_inference_sequencer #(
    parameter int DATA_W  = 32,
    parameter int FRAC_W  = 16,
    parameter int IN_SIZE = 4,
    parameter int H1_SIZE = 64,
    parameter int H2_SIZE = 32,
    parameter int H3_SIZE = 16,
    parameter int ADDR_W  = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    mlp_inference_sequencer_if.slave bus
);
    localparam int NEUR_W = $clog2(H1_SIZE);
    localparam int CNT_W  = $clog2(H1_SIZE + 2);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, OUT} state_t;

    state_t              state;
    logic [1:0]          layer;
    logic [NEUR_W-1:0]   neuron;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   acc;
    logic                in_ready_q, wmem_rd_q, out_valid_q, busy_q;
    logic [ADDR_W-1:0]   wmem_addr_q;
    logic [DATA_W-1:0]   soh_q;
    logic [DATA_W-1:0]   buf_a [H1_SIZE];
    logic [DATA_W-1:0]   buf_b [H1_SIZE];

    function automatic logic [CNT_W-1:0] fan_in(input logic [1:0] l);
        case (l)
            2'd0:    return CNT_W'(IN_SIZE);
            2'd1:    return CNT_W'(H1_SIZE);
            2'd2:    return CNT_W'(H2_SIZE);
            default: return CNT_W'(H3_SIZE);
        endcase
    endfunction

    function automatic logic [NEUR_W-1:0] last_neuron(input logic [1:0] l);
        case (l)
            2'd0:    return NEUR_W'(H1_SIZE - 1);
            2'd1:    return NEUR_W'(H2_SIZE - 1);
            2'd2:    return NEUR_W'(H3_SIZE - 1);
            default: return '0;
        endcase
    endfunction

    // Returned weight j pairs with activation j, which is consumed two cycles after its read slot.
    logic [NEUR_W-1:0]          widx;
    logic [DATA_W-1:0]          act;
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]          mac;
    logic [DATA_W-1:0]          result;

    assign widx   = NEUR_W'(cnt - CNT_W'(2));
    assign act    = layer[0] ? buf_b[widx] : buf_a[widx];
    assign prod   = $signed(act) * $signed(bus.wmem_rdata);
    assign mac    = acc + DATA_W'(prod >> FRAC_W);
    assign result = (layer != 2'd3 && acc[DATA_W-1]) ? '0 : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            layer       <= '0;
            neuron      <= '0;
            cnt         <= '0;
            acc         <= '0;
            in_ready_q  <= 1'b1;
            wmem_rd_q   <= 1'b0;
            wmem_addr_q <= '0;
            out_valid_q <= 1'b0;
            soh_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    state       <= ISSUE;
                    in_ready_q  <= 1'b0;
                    busy_q      <= 1'b1;
                    wmem_rd_q   <= 1'b1;
                    wmem_addr_q <= '0;
                    layer       <= '0;
                    neuron      <= '0;
                    cnt         <= '0;
                end
                ISSUE: begin
                    if (cnt == CNT_W'(1))  acc <= bus.wmem_rdata;
                    else if (cnt != '0)    acc <= mac;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == fan_in(layer)) begin
                        state     <= DRAIN;
                        wmem_rd_q <= 1'b0;
                    end else begin
                        wmem_addr_q <= wmem_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    acc   <= mac;
                    state <= WRITE;
                end
                WRITE: begin
                    cnt <= '0;
                    // The memory image is dense, so the next neuron's bias is always the next word.
                    if (neuron != last_neuron(layer) || layer != 2'd3) begin
                        state       <= ISSUE;
                        wmem_rd_q   <= 1'b1;
                        wmem_addr_q <= wmem_addr_q + ADDR_W'(1);
                        if (neuron != last_neuron(layer)) begin
                            neuron <= neuron + NEUR_W'(1);
                        end else begin
                            neuron <= '0;
                            layer  <= layer + 2'd1;
                        end
                    end else begin
                        state       <= OUT;
                        out_valid_q <= 1'b1;
                        soh_q       <= acc;
                    end
                end
                OUT: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    layer       <= '0;
                    wmem_addr_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Activation storage needs no reset: every entry is written before it is read in a run.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            for (int i = 0; i < IN_SIZE; i++)
                buf_a[i] <= bus.in_data[(IN_SIZE-1-i)*DATA_W +: DATA_W];
        end else if (state == WRITE && layer != 2'd3) begin
            if (layer[0]) buf_a[neuron] <= result;
            else          buf_b[neuron] <= result;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.wmem_rd   = wmem_rd_q;
    assign bus.wmem_addr = wmem_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.soh_out   = soh_q;
    assign bus.busy      = busy_q;
    assign bus.layer_idx = layer;
endmodule
